// File: rtl/game_input_pkg.sv
// Shared types and keycode decoding for the keyboard-to-game input path.
// Used by move_input_scheduler and any other block that consumes PS/2 move keys.
package game_input_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'b000,
    DIR_UP    = 3'b001,
    DIR_LEFT  = 3'b010,
    DIR_DOWN  = 3'b100,
    DIR_RIGHT = 3'b101
  } dir_t;

  typedef enum logic {
    PS_IDLE = 1'b0,
    PS_HELD = 1'b1
  } press_state_t;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_UP    = 8'h1D;
  localparam logic [7:0] KC_LEFT  = 8'h1C;
  localparam logic [7:0] KC_DOWN  = 8'h1B;
  localparam logic [7:0] KC_RIGHT = 8'h23;

  function automatic dir_t keycode_to_dir(input logic [7:0] kc);
    case (kc)
      KC_UP:    return DIR_UP;
      KC_LEFT:  return DIR_LEFT;
      KC_DOWN:  return DIR_DOWN;
      KC_RIGHT: return DIR_RIGHT;
      default:  return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/move_input_scheduler_if.sv
// Move handshake between the input scheduler (master) and the game engine (slave).
// QUEUE_COUNT width follows the scheduler's FIFO_DEPTH.
interface move_input_scheduler_if #(
  parameter int FIFO_DEPTH = 4
);

  logic                          MOVE_VALID;
  logic [2:0]                    MOVE_DIR;
  logic                          MOVE_READY;
  logic [$clog2(FIFO_DEPTH):0]   QUEUE_COUNT;

  modport master (
    output MOVE_VALID,
    output MOVE_DIR,
    output QUEUE_COUNT,
    input  MOVE_READY
  );

  modport slave (
    input  MOVE_VALID,
    input  MOVE_DIR,
    input  QUEUE_COUNT,
    output MOVE_READY
  );

endinterface

// File: rtl/move_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and a dropped-push strobe.
// Output data is the registered head entry; there is no fall-through path.
module move_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  input  logic                    i_flush,
  output logic [WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_valid,
  output logic                    o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_valid  = (r_count != '0);
  assign w_full   = (r_count == CNT_FULL);
  assign o_data   = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  // A pop frees the slot the incoming push lands in, so push+pop on a full queue is legal.
  assign w_do_pop  = i_pop & o_valid & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);
  assign o_drop    = i_push & ~i_flush & w_full & ~w_do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/move_input_scheduler.sv
// Turns PS/2 keycodes into queued move commands, one per fresh press, with a valid/ready output.
// Define AUTO_REPEAT_EN to add held-key auto-repeat (REPEAT_DELAY, then every REPEAT_RATE cycles).
module move_input_scheduler
  import game_input_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [7:0]              KEYCODE,
  input  logic                    ENABLE,
  input  logic                    FLUSH,
  output logic                    OVERFLOW,
  move_input_scheduler_if.master  mv
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("move_input_scheduler: FIFO_DEPTH must be a power of 2 >= 2 and repeat timings >= 1");
  end

  logic [7:0]                  r_kc_q;
  logic [7:0]                  r_held_code;
  press_state_t                r_state;
  logic                        r_overflow;
  dir_t                        w_kc_dir;
  logic                        w_kc_is_move;
  logic                        w_fresh;
  logic                        w_push_req;
  logic                        w_push;
  logic [2:0]                  w_push_dir;
  logic                        w_drop;
  logic [2:0]                  w_head_dir;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                        w_valid;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_kc_q <= KC_NONE;
    end else begin
      r_kc_q <= KEYCODE;
    end
  end

  assign w_kc_dir     = keycode_to_dir(r_kc_q);
  assign w_kc_is_move = (w_kc_dir != DIR_NONE);
  assign w_fresh      = w_kc_is_move & ((r_state == PS_IDLE) | (r_kc_q != r_held_code));

  // Press tracker: the FSM advances even when ENABLE gates the push away.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= PS_IDLE;
      r_held_code <= KC_NONE;
    end else begin
      case (r_state)
        PS_IDLE: begin
          if (w_kc_is_move) begin
            r_held_code <= r_kc_q;
            r_state     <= PS_HELD;
          end
        end
        PS_HELD: begin
          if (!w_kc_is_move) begin
            r_state <= PS_IDLE;
          end else if (r_kc_q != r_held_code) begin
            r_held_code <= r_kc_q;
          end
        end
        default: r_state <= PS_IDLE;
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [31:0] r_rpt_cnt;
  logic        r_rpt_first;
  logic        w_rpt_hold;
  logic        w_rpt_fire;
  logic [31:0] w_rpt_limit;

  assign w_rpt_hold  = (r_state == PS_HELD) & (r_kc_q == r_held_code);
  assign w_rpt_limit = r_rpt_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1);
  assign w_rpt_fire  = w_rpt_hold & (r_rpt_cnt == w_rpt_limit);

  // Any break in holding the same key restarts the long initial delay.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (!w_rpt_hold) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
    end else if (w_rpt_fire) begin
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b0;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + 32'd1;
    end
  end

  assign w_push_req = w_fresh | w_rpt_fire;
  assign w_push_dir = w_fresh ? w_kc_dir : keycode_to_dir(r_held_code);
`else
  assign w_push_req = w_fresh;
  assign w_push_dir = w_kc_dir;
`endif

  assign w_push = w_push_req & ENABLE;

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .i_push  (w_push),
    .i_data  (w_push_dir),
    .i_pop   (mv.MOVE_READY),
    .i_flush (FLUSH),
    .o_data  (w_head_dir),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_drop  (w_drop)
  );

  assign mv.MOVE_VALID  = w_valid;
  assign mv.MOVE_DIR    = w_head_dir;
  assign mv.QUEUE_COUNT = w_count;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_overflow <= 1'b0;
    end else if (FLUSH) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign OVERFLOW = r_overflow;

endmodule

// File: tb/tb_move_input_scheduler.sv
// Directed self-checking bench for move_input_scheduler with FIFO_DEPTH=4.
// With AUTO_REPEAT_EN defined the held-key scenario is replaced by an auto-repeat scenario.
module tb_move_input_scheduler;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [7:0] KEYCODE;
  logic       ENABLE;
  logic       FLUSH;
  logic       OVERFLOW;

  int checkCount = 0;
  int errorCount = 0;

  move_input_scheduler_if #(.FIFO_DEPTH(4)) mif ();

  move_input_scheduler #(
    .FIFO_DEPTH   (4),
    .REPEAT_DELAY (10),
    .REPEAT_RATE  (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .KEYCODE  (KEYCODE),
    .ENABLE   (ENABLE),
    .FLUSH    (FLUSH),
    .OVERFLOW (OVERFLOW),
    .mv       (mif)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] kc, input logic en, input logic fl, input logic rdy);
    KEYCODE        = kc;
    ENABLE         = en;
    FLUSH          = fl;
    mif.MOVE_READY = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pressRelease(input logic [7:0] kc);
    applyStimulus(kc, 1'b1, 1'b0, 1'b0);
    tick(2);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    tick(2);
  endtask

  logic [2:0] drainExp [4];

  initial begin
    RESET_N = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_valid", 32'(mif.MOVE_VALID), 32'd0);
    checkOutput("rst_dir", 32'(mif.MOVE_DIR), 32'd0);
    checkOutput("rst_count", 32'(mif.QUEUE_COUNT), 32'd0);
    checkOutput("rst_ovf", 32'(OVERFLOW), 32'd0);
    RESET_N = 1'b1;
    tick(1);

    $display("[TB] tap");
    applyStimulus(8'h1D, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("tap_lat1", 32'(mif.MOVE_VALID), 32'd0);
    tick(1);
    checkOutput("tap_lat2", 32'(mif.MOVE_VALID), 32'd1);
    checkOutput("tap_dir", 32'(mif.MOVE_DIR), 32'd1);
    tick(3);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    tick(3);
    checkOutput("tap_single", 32'(mif.QUEUE_COUNT), 32'd1);
    mif.MOVE_READY = 1'b1;
    tick(1);
    mif.MOVE_READY = 1'b0;
    checkOutput("tap_pop_count", 32'(mif.QUEUE_COUNT), 32'd0);
    checkOutput("tap_pop_valid", 32'(mif.MOVE_VALID), 32'd0);

`ifndef AUTO_REPEAT_EN
    $display("[TB] held then switch");
    applyStimulus(8'h1D, 1'b1, 1'b0, 1'b0);
    tick(100);
    applyStimulus(8'h23, 1'b1, 1'b0, 1'b0);
    tick(3);
    checkOutput("held_count", 32'(mif.QUEUE_COUNT), 32'd2);
    checkOutput("held_head", 32'(mif.MOVE_DIR), 32'd1);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    tick(1);
    checkOutput("held_second", 32'(mif.MOVE_DIR), 32'd5);
    tick(1);
    mif.MOVE_READY = 1'b0;
    checkOutput("held_drained", 32'(mif.QUEUE_COUNT), 32'd0);
`else
    begin
      int hits = 0;
      int offs [8];
      $display("[TB] auto repeat");
      for (int i = 0; i < 8; i++) offs[i] = 0;
      applyStimulus(8'h1C, 1'b1, 1'b0, 1'b1);
      for (int c = 1; c <= 40; c++) begin
        tick(1);
        if (mif.MOVE_VALID) begin
          checkOutput("rpt_dir", 32'(mif.MOVE_DIR), 32'd2);
          if (hits < 8) offs[hits] = c;
          hits++;
        end
        if (c == 30) KEYCODE = 8'h00;
      end
      mif.MOVE_READY = 1'b0;
      checkOutput("rpt_total", 32'(hits), 32'd6);
      checkOutput("rpt_press", 32'(offs[0]), 32'd2);
      checkOutput("rpt_first", 32'(offs[1]), 32'd12);
      checkOutput("rpt_second", 32'(offs[2]), 32'd16);
    end
`endif

    $display("[TB] overflow");
    pressRelease(8'h1D);
    pressRelease(8'h1C);
    pressRelease(8'h1B);
    pressRelease(8'h23);
    pressRelease(8'h1D);
    tick(1);
    checkOutput("ovf_count", 32'(mif.QUEUE_COUNT), 32'd4);
    checkOutput("ovf_flag", 32'(OVERFLOW), 32'd1);
    drainExp[0] = 3'b001; drainExp[1] = 3'b010; drainExp[2] = 3'b100; drainExp[3] = 3'b101;
    mif.MOVE_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_pop%0d", i), 32'(mif.MOVE_DIR), 32'(drainExp[i]));
      tick(1);
    end
    mif.MOVE_READY = 1'b0;
    checkOutput("ovf_drained", 32'(mif.QUEUE_COUNT), 32'd0);
    checkOutput("ovf_sticky", 32'(OVERFLOW), 32'd1);

    applyStimulus(8'h00, 1'b1, 1'b1, 1'b0);
    tick(1);
    FLUSH = 1'b0;
    checkOutput("flush_clr_ovf", 32'(OVERFLOW), 32'd0);

    $display("[TB] push and pop on full");
    pressRelease(8'h1D);
    pressRelease(8'h1C);
    pressRelease(8'h1B);
    pressRelease(8'h23);
    checkOutput("full_count", 32'(mif.QUEUE_COUNT), 32'd4);
    applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0);
    tick(1);
    mif.MOVE_READY = 1'b1;
    tick(1);
    mif.MOVE_READY = 1'b0;
    checkOutput("pp_count", 32'(mif.QUEUE_COUNT), 32'd4);
    checkOutput("pp_ovf", 32'(OVERFLOW), 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    tick(2);
    drainExp[0] = 3'b010; drainExp[1] = 3'b100; drainExp[2] = 3'b101; drainExp[3] = 3'b010;
    mif.MOVE_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("pp_pop%0d", i), 32'(mif.MOVE_DIR), 32'(drainExp[i]));
      tick(1);
    end
    mif.MOVE_READY = 1'b0;
    checkOutput("pp_drained", 32'(mif.QUEUE_COUNT), 32'd0);

    $display("[TB] disabled input");
    applyStimulus(8'h1B, 1'b0, 1'b0, 1'b0);
    tick(3);
    ENABLE = 1'b1;
    tick(3);
    checkOutput("dis_none", 32'(mif.QUEUE_COUNT), 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    tick(2);
    applyStimulus(8'h1B, 1'b1, 1'b0, 1'b0);
    tick(3);
    checkOutput("dis_repress_count", 32'(mif.QUEUE_COUNT), 32'd1);
    checkOutput("dis_repress_dir", 32'(mif.MOVE_DIR), 32'd4);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    tick(1);
    mif.MOVE_READY = 1'b0;
    tick(1);

    $display("[TB] flush with press");
    pressRelease(8'h1D);
    pressRelease(8'h1C);
    pressRelease(8'h1B);
    checkOutput("fl_pre_count", 32'(mif.QUEUE_COUNT), 32'd3);
    applyStimulus(8'h23, 1'b1, 1'b0, 1'b0);
    tick(1);
    FLUSH = 1'b1;
    tick(1);
    FLUSH = 1'b0;
    checkOutput("fl_count", 32'(mif.QUEUE_COUNT), 32'd0);
    checkOutput("fl_valid", 32'(mif.MOVE_VALID), 32'd0);
    checkOutput("fl_ovf", 32'(OVERFLOW), 32'd0);
    tick(3);
    checkOutput("fl_push_dropped", 32'(mif.QUEUE_COUNT), 32'd0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    tick(2);

    $display("[TB] async reset mid-handshake");
    pressRelease(8'h1D);
    pressRelease(8'h1C);
    mif.MOVE_READY = 1'b1;
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(mif.MOVE_VALID), 32'd0);
    checkOutput("ar_count", 32'(mif.QUEUE_COUNT), 32'd0);
    checkOutput("ar_dir", 32'(mif.MOVE_DIR), 32'd0);
    checkOutput("ar_ovf", 32'(OVERFLOW), 32'd0);
    mif.MOVE_READY = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(3);
    checkOutput("ar_idle", 32'(mif.QUEUE_COUNT), 32'd0);
    applyStimulus(8'h1C, 1'b1, 1'b0, 1'b0);
    tick(3);
    checkOutput("ar_after_count", 32'(mif.QUEUE_COUNT), 32'd1);
    checkOutput("ar_after_dir", 32'(mif.MOVE_DIR), 32'd2);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
